// File: rtl/apb3_fabric_pkg.sv
// apb3_fabric_pkg: shared types and constants for the APB3 fabric.
//   - state_e         : transfer state machine encoding
//   - NSLOTS          : number of requester slots (16)
//   - SLOT_IDX_W      : width of the slot-index field decoded from PADDR
//   - SLOT_EN_DEFAULT : default populated-slot mask (slots 1..5)
//   - slot_onehot()   : slot index to one-hot select vector
package apb3_fabric_pkg;

   localparam int unsigned NSLOTS     = 16;
   localparam int unsigned SLOT_IDX_W = 4;

   localparam logic [NSLOTS-1:0] SLOT_EN_DEFAULT = 16'h003E;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } state_e;

   function automatic logic [NSLOTS-1:0] slot_onehot(input logic [SLOT_IDX_W-1:0] idx);
      logic [NSLOTS-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/apb3_fabric_wdog.sv
// apb3_fabric_wdog: access-phase watchdog for apb3_fabric.
// Only instantiated when APB3_FABRIC_TIMEOUT_EN is defined.
// Ports:
//   clk    in  clock, rising edge
//   rst    in  synchronous active-high reset
//   clr    in  clear the count (asserted while the fabric is in SETUP)
//   run    in  count this cycle (ACCESS without the selected slot's ready)
//   expire out this waiting cycle is the TIMEOUT_CYC-th one; abort now
module apb3_fabric_wdog #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic run,
   output logic expire
);

   localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYC - 1);

   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (run) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // cnt_q holds the waiting cycles already elapsed, so the current cycle is
   // number cnt_q+1; a ready in this same cycle masks run and wins.
   assign expire = run && (cnt_q == LIMIT);

endmodule

// File: rtl/apb3_fabric.sv
// apb3_fabric: registered APB3 interconnect, one completer port to 16
// requester slots. Slot index = PADDR[DEC_LSB+3:DEC_LSB]. Every transfer is
// re-timed through IDLE -> SETUP -> ACCESS -> RESP; disabled slots get an
// immediate error response.
// Optional feature: define APB3_FABRIC_TIMEOUT_EN to add an access-phase
// watchdog (TIMEOUT_CYC cycles) that aborts with PSLVERR=1.
// Ports:
//   PCLK, PRESET                clock, synchronous active-high reset
//   PSEL, PENABLE, PWRITE       master-side controls
//   PADDR, PWDATA               master address / write data
//   PRDATA, PREADY, PSLVERR     registered response to the master
//   PSELS                       one-hot slot selects
//   PENABLES, PWRITES           slave-side controls
//   PADDRS, PWDATAS             latched address / write data
//   PRDATAS                     slot n read data at [n*DATA_W +: DATA_W]
//   PREADYS, PSLVERRS           per-slot ready / error
import apb3_fabric_pkg::*;

module apb3_fabric #(
   parameter int unsigned       DATA_W      = 32,
   parameter int unsigned       ADDR_W      = 32,
   parameter int unsigned       DEC_LSB     = 12,
   parameter logic [NSLOTS-1:0] SLOT_EN     = SLOT_EN_DEFAULT,
   parameter int unsigned       TIMEOUT_CYC = 255
) (
   input  logic                     PCLK,
   input  logic                     PRESET,
   input  logic                     PSEL,
   input  logic                     PENABLE,
   input  logic                     PWRITE,
   input  logic [ADDR_W-1:0]        PADDR,
   input  logic [DATA_W-1:0]        PWDATA,
   output logic [DATA_W-1:0]        PRDATA,
   output logic                     PREADY,
   output logic                     PSLVERR,
   output logic [NSLOTS-1:0]        PSELS,
   output logic                     PENABLES,
   output logic                     PWRITES,
   output logic [ADDR_W-1:0]        PADDRS,
   output logic [DATA_W-1:0]        PWDATAS,
   input  logic [NSLOTS*DATA_W-1:0] PRDATAS,
   input  logic [NSLOTS-1:0]        PREADYS,
   input  logic [NSLOTS-1:0]        PSLVERRS
);

   state_e                  state_q, state_d;
   logic [ADDR_W-1:0]       addr_q, addr_d;
   logic [DATA_W-1:0]       wdata_q, wdata_d;
   logic                    write_q, write_d;
   logic [SLOT_IDX_W-1:0]   slot_q, slot_d;
   logic [DATA_W-1:0]       rdata_q, rdata_d;
   logic                    err_q, err_d;

   logic [SLOT_IDX_W-1:0]   req_slot;
   logic                    sel_ready;
   logic                    sel_err;
   logic [DATA_W-1:0]       sel_rdata;
   logic                    timeout;

   assign req_slot  = PADDR[DEC_LSB +: SLOT_IDX_W];
   assign sel_ready = PREADYS[slot_q];
   assign sel_err   = PSLVERRS[slot_q];
   assign sel_rdata = PRDATAS[32'(slot_q) * DATA_W +: DATA_W];

   // PENABLE carries no information here: a transfer starts on PSEL alone.
   logic unused_inputs;

`ifdef APB3_FABRIC_TIMEOUT_EN
   apb3_fabric_wdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_wdog (
      .clk    (PCLK),
      .rst    (PRESET),
      .clr    (state_q == SETUP),
      .run    ((state_q == ACCESS) && !sel_ready),
      .expire (timeout)
   );
   assign unused_inputs = PENABLE;
`else
   assign timeout       = 1'b0;
   assign unused_inputs = PENABLE ^ (TIMEOUT_CYC != 0);
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      write_d = write_q;
      slot_d  = slot_q;
      rdata_d = '0;
      err_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (PSEL) begin
               addr_d  = PADDR;
               wdata_d = PWDATA;
               write_d = PWRITE;
               slot_d  = req_slot;
               if (SLOT_EN[req_slot]) begin
                  state_d = SETUP;
               end else begin
                  state_d = RESP;
                  err_d   = 1'b1;
               end
            end
         end
         SETUP: begin
            state_d = ACCESS;
         end
         ACCESS: begin
            if (sel_ready) begin
               state_d = RESP;
               rdata_d = write_q ? '0 : sel_rdata;
               err_d   = sel_err;
            end else if (timeout) begin
               state_d = RESP;
               err_d   = 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // rdata_q/err_q are only loaded on the edge entering RESP and cleared on
   // every other edge, so PRDATA/PSLVERR are zero outside RESP.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
         slot_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         write_q <= write_d;
         slot_q  <= slot_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign PSELS    = ((state_q == SETUP) || (state_q == ACCESS)) ? slot_onehot(slot_q) : '0;
   assign PENABLES = (state_q == ACCESS);
   assign PWRITES  = write_q;
   assign PADDRS   = addr_q;
   assign PWDATAS  = wdata_q;
   assign PRDATA   = rdata_q;
   assign PSLVERR  = err_q;
   assign PREADY   = (state_q == RESP);

endmodule

// File: tb/tb_apb3_fabric.sv
// tb_apb3_fabric: directed, table-driven bench for apb3_fabric (default
// parameters, TIMEOUT_CYC overridden to 4). Each table row is one master
// transfer with the expected slot select, latency and response; a slave
// model asserts the target slot's ready after the row's wait count while
// every other slot drives ready/error/data noise.
module tb_apb3_fabric;

   logic           PCLK = 1'b0;
   logic           PRESET;
   logic           PSEL, PENABLE, PWRITE;
   logic [31:0]    PADDR, PWDATA;
   logic [31:0]    PRDATA;
   logic           PREADY, PSLVERR;
   logic [15:0]    PSELS;
   logic           PENABLES, PWRITES;
   logic [31:0]    PADDRS, PWDATAS;
   logic [511:0]   PRDATAS;
   logic [15:0]    PREADYS, PSLVERRS;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   always #5 PCLK = ~PCLK;

   apb3_fabric #(
      .TIMEOUT_CYC (4)
   ) dut (
      .PCLK     (PCLK),
      .PRESET   (PRESET),
      .PSEL     (PSEL),
      .PENABLE  (PENABLE),
      .PWRITE   (PWRITE),
      .PADDR    (PADDR),
      .PWDATA   (PWDATA),
      .PRDATA   (PRDATA),
      .PREADY   (PREADY),
      .PSLVERR  (PSLVERR),
      .PSELS    (PSELS),
      .PENABLES (PENABLES),
      .PWRITES  (PWRITES),
      .PADDRS   (PADDRS),
      .PWDATAS  (PWDATAS),
      .PRDATAS  (PRDATAS),
      .PREADYS  (PREADYS),
      .PSLVERRS (PSLVERRS)
   );

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] srd;        // target slot read data
      logic        serr;       // target slot error
      int unsigned waits;      // ACCESS cycles with ready low
      logic        drop;       // master drops PSEL from cycle 2
      logic [31:0] exp_rd;
      logic        exp_err;
      logic [15:0] exp_psels;
      int unsigned exp_lat;    // cycle index of the PREADY pulse
   } vec_t;

   localparam int unsigned NV = 11;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_noise(input logic [3:0] tgt, input logic [31:0] srd);
      PREADYS  = ~(16'h0001 << tgt);
      PSLVERRS = ~(16'h0001 << tgt);
      for (int s = 0; s < 16; s++) begin
         PRDATAS[s*32 +: 32] = (s == int'(tgt)) ? srd : (32'hDEAD_0000 | 32'(s));
      end
   endtask

   task automatic xfer(input vec_t v);
      int unsigned cyc;
      int unsigned acc;
      logic [3:0]  tgt;
      logic        seq_ok;
      logic        done;
      logic [15:0] exp_sel;
      logic        exp_en;
      tgt = v.addr[15:12];
      drive_noise(tgt, v.srd);
      PSEL    = 1'b1;
      PENABLE = 1'b0;
      PWRITE  = v.wr;
      PADDR   = v.addr;
      PWDATA  = v.wdata;
      cyc = 0; acc = 0; seq_ok = 1'b1; done = 1'b0;
      while (!done && cyc < 200) begin
         @(posedge PCLK); #1;
         cyc++;
         if (PREADY) begin
            done = 1'b1;
         end else begin
            exp_sel = (cyc < v.exp_lat) ? v.exp_psels : 16'h0000;
            exp_en  = (exp_sel != 16'h0000) && (cyc >= 2);
            if (PSELS !== exp_sel || PENABLES !== exp_en) begin
               if (seq_ok)
                  $display("FAIL psels_seq cyc %0d: got sel=%0h en=%0b expected sel=%0h en=%0b",
                           cyc, PSELS, PENABLES, exp_sel, exp_en);
               seq_ok = 1'b0;
            end
            if (PENABLES && PSELS[tgt]) begin
               acc++;
               if (acc > v.waits) begin
                  PREADYS[tgt]  = 1'b1;
                  PSLVERRS[tgt] = v.serr;
               end
            end
            if (cyc == 1) PENABLE = 1'b1;
            if (v.drop && cyc >= 2) begin
               PSEL    = 1'b0;
               PENABLE = 1'b0;
            end
         end
      end
      check("completed", 64'(done), 64'(1));
      check("psels_seq_ok", 64'(seq_ok), 64'(1));
      check("latency", 64'(cyc), 64'(v.exp_lat));
      check("prdata", 64'(PRDATA), 64'(v.exp_rd));
      check("pslverr", 64'(PSLVERR), 64'(v.exp_err));
      check("resp_psels", 64'({PSELS, PENABLES}), 64'(0));
      check("paddrs", 64'(PADDRS), 64'(v.addr));
      check("pwdatas", 64'(PWDATAS), 64'(v.wdata));
      check("pwrites", 64'(PWRITES), 64'(v.wr));
      PSEL     = 1'b0;
      PENABLE  = 1'b0;
      PREADYS  = '0;
      PSLVERRS = '0;
      @(posedge PCLK); #1;
      check("idle_resp", 64'({PREADY, PSLVERR, PRDATA, PSELS}), 64'(0));
      check("paddrs_hold", 64'(PADDRS), 64'(v.addr));
   endtask

   initial begin
      //            wr  addr          wdata         srd           serr wt  drop exp_rd        err psels     lat
      vecs[0]  = '{1'b0, 32'h0000_1004, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 0, 1'b0, 32'hCAFE_F00D, 1'b0, 16'h0002, 3};
      vecs[1]  = '{1'b1, 32'h0000_5010, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 3, 1'b0, 32'h0000_0000, 1'b0, 16'h0020, 6};
      vecs[2]  = '{1'b0, 32'h0000_9000, 32'h0000_0009, 32'h1111_1111, 1'b0, 0, 1'b0, 32'h0000_0000, 1'b1, 16'h0000, 1};
      vecs[3]  = '{1'b0, 32'h0000_3008, 32'hA5A5_0003, 32'h0BAD_BEEF, 1'b1, 1, 1'b0, 32'h0BAD_BEEF, 1'b1, 16'h0008, 4};
      vecs[4]  = '{1'b1, 32'h0000_0FFC, 32'hDEAD_0000, 32'h2222_2222, 1'b0, 0, 1'b0, 32'h0000_0000, 1'b1, 16'h0000, 1};
      vecs[5]  = '{1'b0, 32'hFFFF_4000, 32'h0000_0000, 32'h7654_3210, 1'b0, 0, 1'b0, 32'h7654_3210, 1'b0, 16'h0010, 3};
      vecs[6]  = '{1'b0, 32'h0000_6000, 32'h0000_0066, 32'h3333_3333, 1'b0, 0, 1'b0, 32'h0000_0000, 1'b1, 16'h0000, 1};
      vecs[7]  = '{1'b0, 32'h0000_2000, 32'h0000_0000, 32'h2468_ACE0, 1'b0, 3, 1'b0, 32'h2468_ACE0, 1'b0, 16'h0004, 6};
      vecs[8]  = '{1'b0, 32'h0000_1FF0, 32'h0000_0000, 32'h0F0F_0F0F, 1'b0, 2, 1'b1, 32'h0F0F_0F0F, 1'b0, 16'h0002, 5};
`ifdef APB3_FABRIC_TIMEOUT_EN
      vecs[9]  = '{1'b0, 32'h0000_2004, 32'h0000_0000, 32'h9999_9999, 1'b0, 1000, 1'b0, 32'h0000_0000, 1'b1, 16'h0004, 6};
`else
      vecs[9]  = '{1'b0, 32'h0000_2004, 32'h0000_0000, 32'h9999_9999, 1'b0, 20, 1'b0, 32'h9999_9999, 1'b0, 16'h0004, 23};
`endif
      vecs[10] = '{1'b1, 32'h0000_F000, 32'hF00F_F00F, 32'h4444_4444, 1'b0, 0, 1'b0, 32'h0000_0000, 1'b1, 16'h0000, 1};

      PRESET   = 1'b1;
      PSEL     = 1'b0;
      PENABLE  = 1'b0;
      PWRITE   = 1'b0;
      PADDR    = '0;
      PWDATA   = '0;
      PRDATAS  = '0;
      PREADYS  = '0;
      PSLVERRS = '0;
      repeat (3) @(posedge PCLK);
      #1;
      check("reset_ctrl", 64'({PSELS, PENABLES, PWRITES, PREADY, PSLVERR}), 64'(0));
      check("reset_paddrs", 64'(PADDRS), 64'(0));
      check("reset_pwdatas", 64'(PWDATAS), 64'(0));
      check("reset_prdata", 64'(PRDATA), 64'(0));
      PRESET = 1'b0;

      for (int i = 0; i < int'(NV); i++) begin
         xfer(vecs[i]);
      end

      // Reset during ACCESS of slot 3 aborts without a response pulse.
      drive_noise(4'd3, 32'h5555_5555);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
      PADDR = 32'h0000_3000; PWDATA = 32'h0000_55AA;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(posedge PCLK); #1;
      check("rst_pre_access", 64'({PSELS, PENABLES}), 64'({16'h0008, 1'b1}));
      PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0;
      @(posedge PCLK); #1;
      check("rst_mid_ctrl", 64'({PSELS, PENABLES, PWRITES, PREADY, PSLVERR}), 64'(0));
      check("rst_mid_paddrs", 64'(PADDRS), 64'(0));
      check("rst_mid_pwdatas", 64'(PWDATAS), 64'(0));
      check("rst_mid_prdata", 64'(PRDATA), 64'(0));
      PRESET = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge PCLK); #1;
         check("rst_no_resp", 64'({PREADY, PSELS}), 64'(0));
      end
      PREADYS = '0; PSLVERRS = '0;
      xfer('{1'b0, 32'h0000_4010, 32'h0000_0000, 32'hBEEF_0004, 1'b0, 1, 1'b0, 32'hBEEF_0004, 1'b0, 16'h0010, 4});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
